// File: rtl/ram_sync_dp_be.sv
// Simple dual-port synchronous RAM with byte-enable writes, a 1- or 2-stage
// registered read path and a post-reset clear sweep that holds off requests.
module ram_sync_dp_be #(
  parameter int unsigned AWIDTH     = 3,
  parameter int unsigned DWIDTH     = 32,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned RDW_MODE   = 0,
  parameter int unsigned INIT_CLEAR = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [AWIDTH-1:0]   wr_addr,
  input  logic [DWIDTH/8-1:0] wr_be,
  input  logic [DWIDTH-1:0]   wr_data,
  input  logic                rd_en,
  input  logic [AWIDTH-1:0]   rd_addr,
  output logic [DWIDTH-1:0]   rd_data,
  output logic                rd_valid,
  output logic                busy
);

  localparam int unsigned DEPTH  = 1 << AWIDTH;
  localparam int unsigned NBYTES = DWIDTH / 8;

  typedef enum logic {CLEAR, READY} state_e;

  state_e              state_q, state_d;
  logic [AWIDTH-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DWIDTH-1:0]   mem_q [DEPTH];
  logic [DWIDTH-1:0]   be_mask;
  logic [DWIDTH-1:0]   wr_word;
  logic [DWIDTH-1:0]   s1_data_d;
  logic                wr_fire, rd_fire, clr_fire;
  logic                s1_valid_q;
  logic [DWIDTH-1:0]   s1_data_q;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == '1) state_d = READY;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= (INIT_CLEAR != 0) ? CLEAR : READY;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign clr_fire = (state_q == CLEAR);
  assign wr_fire  = (state_q == READY) && wr_en;
  assign rd_fire  = (state_q == READY) && rd_en;
  assign busy     = reset || (state_q == CLEAR);

  for (genvar g = 0; g < NBYTES; g++) begin : g_mask
    assign be_mask[8*g +: 8] = {8{wr_be[g]}};
  end

  assign wr_word = (mem_q[wr_addr] & ~be_mask) | (wr_data & be_mask);

  // New-data mode forwards the merged write word instead of the stored one.
  always_comb begin
    s1_data_d = mem_q[rd_addr];
    if ((RDW_MODE != 0) && wr_fire && (wr_addr == rd_addr))
      s1_data_d = wr_word;
  end

  always_ff @(posedge clock) begin
    if (clr_fire)
      mem_q[clr_cnt_q] <= '0;
    else if (wr_fire)
      mem_q[wr_addr] <= wr_word;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= rd_fire;
      if (rd_fire) s1_data_q <= s1_data_d;
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic              s2_valid_q;
    logic [DWIDTH-1:0] s2_data_q;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) s2_data_q <= s1_data_q;
      end
    end

    assign rd_valid = s2_valid_q;
    assign rd_data  = s2_data_q;
  end else begin : g_lat1
    assign rd_valid = s1_valid_q;
    assign rd_data  = s1_data_q;
  end

endmodule

// File: tb/tb_ram_sync_dp_be.sv
// Randomized self-checking bench: three RAM configurations share one stimulus
// stream and are compared against an array-based behavioural model each cycle.
module tb_ram_sync_dp_be;

  localparam int NI    = 3;
  localparam int DEPTH = 8;

  logic        clock   = 1'b0;
  logic        reset   = 1'b0;
  logic        wr_en   = 1'b0;
  logic        rd_en   = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [2:0]  rd_addr = '0;
  logic [3:0]  wr_be   = '0;
  logic [31:0] wr_data = '0;

  logic [31:0] d_a, d_b, d_c;
  logic        v_a, v_b, v_c;
  logic        b_a, b_b, b_c;

  always #5 clock = ~clock;

  ram_sync_dp_be #(.AWIDTH(3), .DWIDTH(32), .RD_LATENCY(1), .RDW_MODE(0), .INIT_CLEAR(1)) u_a (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d_a), .rd_valid(v_a), .busy(b_a));

  ram_sync_dp_be #(.AWIDTH(3), .DWIDTH(32), .RD_LATENCY(2), .RDW_MODE(1), .INIT_CLEAR(1)) u_b (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d_b), .rd_valid(v_b), .busy(b_b));

  ram_sync_dp_be #(.AWIDTH(3), .DWIDTH(32), .RD_LATENCY(1), .RDW_MODE(1), .INIT_CLEAR(0)) u_c (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d_c), .rd_valid(v_c), .busy(b_c));

  int lat   [NI] = '{1, 2, 1};
  int rdw   [NI] = '{0, 1, 1};
  int initc [NI] = '{1, 1, 0};

  logic [31:0] dut_d [NI];
  logic        dut_v [NI];
  logic        dut_b [NI];
  assign dut_d[0] = d_a;  assign dut_d[1] = d_b;  assign dut_d[2] = d_c;
  assign dut_v[0] = v_a;  assign dut_v[1] = v_b;  assign dut_v[2] = v_c;
  assign dut_b[0] = b_a;  assign dut_b[1] = b_b;  assign dut_b[2] = b_c;

  // Reference model: memory image, remaining sweep cycles, results keyed by due cycle.
  logic [31:0] m_mem  [NI][DEPTH];
  int          m_busy [NI];
  logic [31:0] m_last [NI];
  logic        m_expv [NI];
  logic        m_sv   [NI][4];
  logic [31:0] m_sd   [NI][4];

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic check_all(input string phase);
    for (int k = 0; k < NI; k++) begin
      check_eq($sformatf("%s.busy%0d@%0d", phase, k, cyc), 32'(dut_b[k]),
               32'((m_busy[k] > 0) || reset));
      check_eq($sformatf("%s.valid%0d@%0d", phase, k, cyc), 32'(dut_v[k]), 32'(m_expv[k]));
      check_eq($sformatf("%s.data%0d@%0d", phase, k, cyc), dut_d[k], m_last[k]);
    end
  endtask

  task automatic model_edge();
    cyc++;
    for (int k = 0; k < NI; k++) begin
      int slot;
      slot = cyc % 4;
      if (!reset) begin
        if (m_busy[k] > 0) begin
          m_mem[k][DEPTH - m_busy[k]] = '0;
          m_busy[k]--;
        end else begin
          if (rd_en) begin
            logic [31:0] r;
            int due;
            r = m_mem[k][rd_addr];
            if (rdw[k] != 0 && wr_en && wr_addr == rd_addr) r = merge(r, wr_data, wr_be);
            due = (cyc + lat[k] - 1) % 4;
            m_sv[k][due] = 1'b1;
            m_sd[k][due] = r;
          end
          if (wr_en) m_mem[k][wr_addr] = merge(m_mem[k][wr_addr], wr_data, wr_be);
        end
      end
      m_expv[k] = m_sv[k][slot];
      if (m_sv[k][slot]) m_last[k] = m_sd[k][slot];
      m_sv[k][slot] = 1'b0;
    end
  endtask

  task automatic step(input string phase);
    @(posedge clock);
    model_edge();
    #1;
    check_all(phase);
  endtask

  task automatic drive(input logic we, input logic [2:0] wa, input logic [3:0] be,
                       input logic [31:0] wd, input logic re, input logic [2:0] ra);
    wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd; rd_en = re; rd_addr = ra;
  endtask

  task automatic do_reset(input int n);
    drive(1'b0, '0, '0, '0, 1'b0, '0);
    reset = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      m_busy[k] = (initc[k] != 0) ? DEPTH : 0;
      m_last[k] = '0;
      m_expv[k] = 1'b0;
      for (int s = 0; s < 4; s++) m_sv[k][s] = 1'b0;
    end
    check_all("rst_assert");
    repeat (n) step("rst_hold");
    reset = 1'b0;
    #1;
    check_all("rst_release");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2;
    do_reset(3);

    // Sweep window: the INIT_CLEAR=0 instance takes full writes, the others ignore them.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 3'(i), 4'hF, $urandom, 1'b0, '0);
      step("sweep");
    end

    drive(1'b1, 3'd2, 4'hF, 32'hAABBCCDD, 1'b0, '0);      step("be");
    drive(1'b1, 3'd2, 4'b0101, 32'h11223344, 1'b0, '0);   step("be");
    drive(1'b0, '0, '0, '0, 1'b1, 3'd2);                  step("be");
    check_eq("be_a_valid", 32'(v_a), 32'd1);
    check_eq("be_a_data", d_a, 32'hAA22CC44);
    check_eq("be_b_not_yet", 32'(v_b), 32'd0);
    drive(1'b0, '0, '0, '0, 1'b0, '0);                    step("be");
    check_eq("be_b_valid", 32'(v_b), 32'd1);
    check_eq("be_b_data", d_b, 32'hAA22CC44);
    check_eq("be_a_drop", 32'(v_a), 32'd0);

    drive(1'b1, 3'd5, 4'hF, 32'hDEADBEEF, 1'b1, 3'd5);    step("rdw");
    check_eq("rdw_old_a", d_a, 32'h00000000);
    drive(1'b0, '0, '0, '0, 1'b1, 3'd5);                  step("rdw");
    check_eq("rdw_new_b", d_b, 32'hDEADBEEF);
    check_eq("rdw_after_a", d_a, 32'hDEADBEEF);
    drive(1'b0, '0, '0, '0, 1'b0, '0);
    step("rdw");
    step("rdw");

    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b1, 3'(k), 4'hF, 32'(k) * 32'h01010101, 1'b0, '0);
      step("stream_wr");
    end
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b0, '0, '0, '0, 1'b1, 3'(k));
      step("stream_rd");
    end
    drive(1'b0, '0, '0, '0, 1'b0, '0);
    repeat (3) step("stream_idle");
    check_eq("stream_hold_a", d_a, 32'h07070707);
    check_eq("stream_hold_b", d_b, 32'h07070707);
    check_eq("stream_idle_a", 32'(v_a), 32'd0);

    repeat (400) begin
      drive(1'($urandom), 3'($urandom), 4'($urandom), $urandom, 1'($urandom), 3'($urandom));
      step("rand");
    end

    // Read in flight for the two-stage instance when reset hits.
    drive(1'b0, '0, '0, '0, 1'b1, 3'd3);
    step("flight");
    do_reset(2);
    check_eq("flight_b_killed", 32'(v_b), 32'd0);

    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'd1, 4'hF, 32'hFFFFFFFF, 1'b0, '0);
      step("midsweep");
    end
    do_reset(2);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 3'(i), 4'hF, $urandom, 1'b0, '0);
      step("resweep");
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, '0, '0, '0, 1'b1, 3'(i));
      step("clr_rb");
      check_eq($sformatf("clr_rb_a%0d", i), d_a, 32'h00000000);
    end

    drive(1'b1, 3'd7, 4'hF, 32'h12345678, 1'b0, '0);      step("c_wr");
    drive(1'b0, '0, '0, '0, 1'b1, 3'd7);                  step("c_rd");
    check_eq("c_rb_data", d_c, 32'h12345678);
    drive(1'b0, '0, '0, '0, 1'b0, '0);
    repeat (3) step("tail");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
